// File: rtl/div_pkg.sv
// Shared types and constants for the divider request sequencer.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// Request queue: DEPTH-entry circular buffer, head visible on pop_dat.
// Latency: a push is visible at the head one cycle later; push and pop may share a cycle.
// Backpressure: push ignored while full, pop ignored while empty.
module div_req_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Queues divide requests and runs them one at a time through an external divider.
// Latency: pop one cycle after accept, div_start the cycle after; div-by-zero answers directly.
// Backpressure: req_ready drops when the queue is full; responses held until rsp_ready.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div0,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int QW = $clog2(DEPTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic             div0_q, div0_d;
    logic             tmo_q, tmo_d;
    logic             done_q;
    logic             rdy_en_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] head_dat;
    logic [WIDTH-1:0]   head_dividend, head_divisor;
    logic [QW:0]        fifo_count;
    logic               done_edge;

    // rdy_en_q keeps req_ready low during reset and until the first edge after release.
    assign req_ready     = rdy_en_q && !fifo_full;
    assign fifo_push     = req_valid && req_ready;
    assign head_dividend = head_dat[2*WIDTH-1:WIDTH];
    assign head_divisor  = head_dat[WIDTH-1:0];
    assign done_edge     = div_done && !done_q;

    div_req_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({req_dividend, req_divisor}),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        rsp_vld_d  = rsp_vld_q;
        div0_d     = div0_q;
        tmo_d      = tmo_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    dividend_d = head_dividend;
                    divisor_d  = head_divisor;
                    if (head_divisor == '0) begin
                        // Divide-by-zero never reaches the divider.
                        state_d   = ST_HOLD;
                        quo_d     = {WIDTH{&DIV0_QUOTIENT}};
                        rem_d     = head_dividend;
                        div0_d    = 1'b1;
                        tmo_d     = 1'b0;
                        rsp_vld_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Only a fresh rising edge counts; a done level left high is stale.
                if (done_edge) begin
                    state_d   = ST_HOLD;
                    quo_d     = div_quotient;
                    rem_d     = div_remainder;
                    div0_d    = 1'b0;
                    tmo_d     = 1'b0;
                    rsp_vld_d = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_HOLD;
                    quo_d     = '0;
                    rem_d     = '0;
                    div0_d    = 1'b0;
                    tmo_d     = 1'b1;
                    rsp_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            div0_q     <= 1'b0;
            tmo_q      <= 1'b0;
            done_q     <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            rsp_vld_q  <= rsp_vld_d;
            div0_q     <= div0_d;
            tmo_q      <= tmo_d;
            done_q     <= div_done;
            rdy_en_q   <= 1'b1;
        end
    end

    assign div_start     = start_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_valid     = rsp_vld_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_div0      = div0_q;
    assign rsp_timeout   = tmo_q;
    assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural divider and random traffic.
module tb_div_sequencer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_dividend = '0;
    logic [W-1:0]  req_divisor = '0;
    logic          div_start;
    logic [W-1:0]  div_dividend, div_divisor;
    logic          div_done = 1'b0;
    logic [W-1:0]  div_quotient = '0;
    logic [W-1:0]  div_remainder = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_quotient, rsp_remainder;
    logic          rsp_div0, rsp_timeout;
    logic          busy;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         div0;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   starts = 0;
    int   exp_starts = 0;
    int   div_mode = 0;    // 0: done pulses, 1: done stays high, 2: divider ignores start
    int   fixed_lat = 34;  // 0 selects a random latency per operation
    int   rdy_mode = 1;    // 0: random, 1: always ready, 2: held low

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endfunction

    // Reference: what a correct sequencer answers for a request, given the divider's behaviour.
    function automatic exp_t model_rsp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0)             e = '{q: {W{1'b1}}, r: a, div0: 1'b1, tmo: 1'b0};
        else if (div_mode == 2) e = '{q: '0, r: '0, div0: 1'b0, tmo: 1'b1};
        else                    e = '{q: a / b, r: a % b, div0: 1'b0, tmo: 1'b0};
        return e;
    endfunction

    // Behavioural divider, driven mid-cycle.
    initial begin
        logic [W-1:0] ma, mb;
        int           mcnt;
        mcnt = 0;
        ma = '0;
        mb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0;
                div_done = 1'b0;
            end else begin
                if (div_mode == 0 && div_done) div_done = 1'b0;
                if (div_start) begin
                    if (div_mode != 2) begin
                        ma = div_dividend;
                        mb = div_divisor;
                        mcnt = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 40);
                    end
                end else if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        div_done = 1'b1;
                        div_quotient = ma / mb;
                        div_remainder = ma % mb;
                    end
                end
            end
        end
    end

    // Monitor: drives rsp_ready and checks every response against the scoreboard.
    initial begin
        exp_t         e;
        logic         prev_vld, prev_held, prev_start;
        logic [65:0]  snap;
        int           cyc, start_cyc;
        prev_vld = 0; prev_held = 0; prev_start = 0; cyc = 0; start_cyc = 0; snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 0; prev_held = 0; prev_start = 0;
            end else begin
                cyc++;
                if (div_start) begin
                    starts++;
                    start_cyc = cyc;
                    if (prev_start) chk("start_single_cycle", 64'(prev_start), 64'(0));
                end
                if (prev_held) begin
                    chk("rsp_stable", 64'({rsp_valid, rsp_quotient[30:0], rsp_remainder, rsp_div0, rsp_timeout}),
                        64'({1'b1, snap[64:34], snap[33:2], snap[1:0]}));
                    chk("no_start_in_hold", 64'(div_start), 64'(0));
                end
                if (rsp_valid && !prev_vld && exp_q.size() > 0 && exp_q[0].tmo)
                    chk("timeout_latency", 64'(cyc - start_cyc), 64'(TO + 1));
                case (rdy_mode)
                    0:       rsp_ready = ($urandom_range(0, 3) != 0);
                    1:       rsp_ready = 1'b1;
                    default: rsp_ready = 1'b0;
                endcase
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_rsp: got response q=%0h r=%0h required none", rsp_quotient, rsp_remainder);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                        chk("rsp_remainder", 64'(rsp_remainder), 64'(e.r));
                        chk("rsp_flags", 64'({rsp_div0, rsp_timeout}), 64'({e.div0, e.tmo}));
                    end
                end
                prev_held = rsp_valid && !rsp_ready;
                snap = {rsp_quotient, rsp_remainder, rsp_div0, rsp_timeout};
                prev_vld = rsp_valid;
                prev_start = div_start;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit rdy, ok;
        int n;
        ok = 0;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_dividend = a;
        req_divisor = b;
        while (!ok && n < 200) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) ok = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        #1 req_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(model_rsp(a, b));
            if (b != 0) exp_starts++;
        end else begin
            checks++;
            $display("FAIL send_accept: got no accept in 200 cycles, required accept");
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_starts(input string name);
        chk(name, 64'(starts), 64'(exp_starts));
        starts = 0;
        exp_starts = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 64'({div_start, rsp_valid, rsp_div0, rsp_timeout, busy, req_ready}), 64'(0));
        chk({name, "_data"}, 64'({div_dividend | div_divisor | rsp_quotient | rsp_remainder}), 64'(0));
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;

        // Reset state and req_ready release timing.
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 chk("ready_after_edge", 64'(req_ready), 64'(1));

        // Two back-to-back requests, first-op latency to div_start.
        fixed_lat = 34;
        rdy_mode = 1;
        send(10, 7);
        @(negedge clk);
        chk("start_n_to_n1", 64'(div_start), 64'(0));
        @(negedge clk);
        chk("start_n1_to_n2", 64'(div_start), 64'(1));
        send(100, 100);
        drain(200);
        check_starts("starts_two_ops");

        // Divide by zero bypass and its response timing.
        send(100, 0);
        @(negedge clk);
        chk("div0_vld_first_cycle", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        chk("div0_vld_second_cycle", 64'({rsp_valid, rsp_div0}), 64'(2'b11));
        drain(20);
        check_starts("starts_div0");

        // Fill the queue behind a running op: four accepts fill it, the fifth waits.
        send(1000, 3);
        repeat (3) @(negedge clk);
        send(100, 7);
        send(70, 150);
        send(33, 4);
        send(9, 9);
        chk("ready_after_fill", 64'(req_ready), 64'(0));
        send(81, 8);
        drain(400);
        check_starts("starts_fill");

        // Response held off: fields stable and no new issue until handshake.
        fixed_lat = 5;
        rdy_mode = 2;
        send(50, 6);
        send(77, 5);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_vld_seen", 64'(rsp_valid), 64'(1));
        repeat (10) @(negedge clk);
        rdy_mode = 1;
        drain(100);
        check_starts("starts_hold");

        // Stale done level from a prior op, then a divider that never answers.
        fixed_lat = 10;
        div_mode = 1;
        send(5, 2);
        drain(100);
        div_mode = 2;
        send(9, 4);
        drain(200);
        div_mode = 0;
        check_starts("starts_timeout");

        // Reset while waiting with two requests queued.
        fixed_lat = 34;
        send(40, 3);
        send(41, 3);
        send(42, 3);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midop_reset");
        exp_q.delete();
        starts = 0;
        exp_starts = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", 64'({busy, rsp_valid}), 64'(0));
        send(20, 3);
        drain(100);
        check_starts("starts_after_reset");

        // Random traffic with random divider latency and response backpressure.
        fixed_lat = 0;
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 500));
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            send(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(6000);
        check_starts("starts_random");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4, request queue entries (power of two, at least 2).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for div_done.
REQ-004 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  system reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_dividend in WIDTH, req_divisor in WIDTH: the request channel.
REQ-007 SHALL have ports div_start out 1, div_dividend out WIDTH, div_divisor out WIDTH: the command to the divider.
REQ-008 SHALL have ports div_done in 1, div_quotient in WIDTH, div_remainder in WIDTH: the divider result.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_quotient out WIDTH, rsp_remainder out WIDTH, rsp_div0 out 1, rsp_timeout out 1: the response channel.
REQ-010 SHALL have port busy  out  1  high when the queue is non-empty or the FSM is not in IDLE.

Function
REQ-011 Request handshake: a request SHALL be accepted on a cycle where req_valid and req_ready are both high. req_ready = queue not full, registered-state only. There is no same-cycle pass-through when full.
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT and HOLD.
REQ-013 IDLE with a non-empty queue SHALL pop the head into the operand registers. It goes to ISSUE when divisor is not 0, otherwise to HOLD.
REQ-014 ISSUE SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-015 div_dividend and div_divisor SHALL stay stable from ISSUE until leaving WAIT.
REQ-016 WAIT SHALL capture div_quotient and div_remainder on a rising edge of div_done (high now, low the previous cycle), then go to HOLD. A level-high done left over from a prior operation SHALL be ignored.
REQ-017 The WAIT cycle counter SHALL start at 0 on entry. If it reaches TIMEOUT-1 without a done edge, the FSM goes to HOLD with rsp_timeout=1 and quotient and remainder = 0.
REQ-018 A divisor of 0 SHALL bypass the divider: rsp_quotient = all ones, rsp_remainder = dividend, rsp_div0=1, div_start stays low. rsp_valid rises on the cycle after the pop.
REQ-019 HOLD SHALL assert rsp_valid, with all rsp_* fields stable until rsp_ready. On the rsp_valid and rsp_ready cycle the FSM goes to IDLE and rsp_valid drops next cycle.
REQ-020 Latency: a request accepted into an empty queue with the FSM in IDLE at edge N SHALL be popped at edge N+1. div_start is high during cycle N+1 to N+2.
REQ-021 Requests SHALL be served strictly in arrival order, one outstanding divider operation at a time.
REQ-022 A queue push and a pop in the same cycle SHALL both take effect, with the count unchanged.
REQ-023 Queue pointers SHALL wrap modulo DEPTH. Full is count = DEPTH and empty is count = 0.
REQ-024 div_done and divider results outside WAIT SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force: FSM to IDLE, queue empty, counter 0, div_start=0, rsp_valid=0, rsp_div0=0, rsp_timeout=0, all data outputs 0, busy=0.
REQ-026 req_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-027 Reset mid-operation SHALL discard queued and in-flight requests, with no response produced.

Structure
REQ-028 Package div_pkg SHALL hold the FSM state typedef, the WIDTH default and the DIV0_QUOTIENT constant (all ones).
REQ-029 The queue SHALL be the sub-module div_req_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count). The FSM, timeout counter and output registers SHALL be in div_sequencer.

Verification
REQ-030 Requests 10/7 then 100/100 back-to-back, with a behavioural divider of fixed 34-cycle latency -> responses (1,3) then (1,0) in order, one div_start each.
REQ-031 Five requests in consecutive cycles with rsp_ready=1 -> req_ready drops after the 4th accept and the 5th waits. All five responses match in order: 100/7=(14,2), 70/150=(0,70).
REQ-032 Request 100/0 -> no div_start; response (0xFFFFFFFF,100) with rsp_div0=1, rsp_valid on the second cycle after accept.
REQ-033 rsp_ready held low 10 cycles during HOLD -> rsp_* stable and no new div_start until the handshake completes.
REQ-034 Divider model never asserts done, and div_done held high from the previous op -> rsp_timeout=1 after exactly 64 WAIT cycles, and no false capture.
REQ-035 rst_n pulsed low in WAIT with 2 queued requests -> outputs at reset values immediately; no responses afterwards, and a new request 20/3 returns (6,2).
